// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet/ARP framing constants and generator state type
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REP     = 16'h0002;

  localparam int ETH_PRE_BYTES = 8;
  localparam int ETH_MIN_BODY  = 60;
  localparam int ETH_FCS_BYTES = 4;
  localparam int ARP_HDR_BYTES = 42;

  // Normal and bit-reflected forms of the IEEE 802.3 polynomial
  localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Register value left after running a good frame including its FCS
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_BODY,
    ST_FCS,
    ST_IFG,
    ST_DONE
  } arp_gen_state_t;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide combinational reflected CRC-32 next-state
module crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  import eth_pkg::*;

  logic [31:0] c;

  // Shift the eight data bits in LSB first through the reflected register
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY_REFL;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/arp_frame_gen.sv
// rtl/arp_frame_gen.sv - burst ARP request/reply frame generator on a GMII/RGMII-SDR style bus
module arp_frame_gen #(
  parameter int          OUT_W     = 8,
  parameter int          IFG_BYTES = 12,
  parameter logic [47:0] SRC_MAC   = 48'h00_11_22_33_44_55,
  parameter logic [31:0] SRC_IP    = 32'hC0_A8_01_0A
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [47:0]      dst_mac,
  input  logic [31:0]      dst_ip,
  input  logic [15:0]      count,
  output logic             busy,
  output logic             done,
  output logic             tx_en,
  output logic [OUT_W-1:0] txd,
  output logic [15:0]      frame_cnt
);
  import eth_pkg::*;

  localparam logic [6:0]  IDX_SFD      = 7'(ETH_PRE_BYTES - 1);
  localparam logic [6:0]  IDX_BODY_END = 7'(ETH_PRE_BYTES + ETH_MIN_BODY - 1);
  localparam logic [6:0]  IDX_FCS_END  = 7'(ETH_PRE_BYTES + ETH_MIN_BODY + ETH_FCS_BYTES - 1);
  localparam logic [15:0] IFG_LAST     = 16'(IFG_BYTES - 1);

  // ARP body byte b (0-based after SFD); everything past the ARP payload is pad
  function automatic logic [7:0] body_byte(input logic [6:0] b, input logic is_rep,
                                           input logic [47:0] mac, input logic [31:0] ip);
    logic [ARP_HDR_BYTES*8-1:0] hdr;
    logic [ARP_HDR_BYTES*8-1:0] sh;
    hdr = {is_rep ? mac : 48'hFFFF_FFFF_FFFF, SRC_MAC, ETHERTYPE_ARP, ARP_HTYPE_ETH,
           ETHERTYPE_IPV4, ARP_HLEN, ARP_PLEN, is_rep ? ARP_OP_REP : ARP_OP_REQ,
           SRC_MAC, SRC_IP, is_rep ? mac : 48'h0, ip};
    sh  = hdr << {b, 3'b000};
    return (b < 7'(ARP_HDR_BYTES)) ? sh[ARP_HDR_BYTES*8-1 -: 8] : 8'h00;
  endfunction

  logic           rst_meta, rst_n_int;
  arp_gen_state_t state, state_nx;
  logic [6:0]     idx;
  logic [15:0]    ifg_cnt;
  logic           ph;
  logic           adv;
  logic [31:0]    crc, crc_next, fcs;
  logic [7:0]     cur_byte;
  logic           op_q;
  logic [47:0]    dst_mac_q;
  logic [31:0]    dst_ip_q;
  logic [15:0]    count_q;

  // A byte-time completes every cycle on the byte bus, every second cycle on the nibble bus
  assign adv   = (OUT_W == 8) || ph;
  assign tx_en = (state == ST_PRE) || (state == ST_BODY) || (state == ST_FCS);
  assign done  = (state == ST_DONE);
  assign busy  = (state != ST_IDLE) && (count_q != 16'd0);
  assign fcs   = ~crc;

  // Reset asserts asynchronously and releases on a clock edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) {rst_meta, rst_n_int} <= 2'b00;
    else            {rst_meta, rst_n_int} <= {1'b1, rst_meta};
  end

  // State register
  always_ff @(posedge sys_clk or negedge rst_n_int) begin
    if (!rst_n_int) state <= ST_IDLE;
    else            state <= state_nx;
  end

  // Next-state: preamble, body, FCS, gap, then another frame or burst end
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = (count == 16'd0) ? ST_DONE : ST_PRE;
      ST_PRE:  if (adv && idx == IDX_SFD) state_nx = ST_BODY;
      ST_BODY: if (adv && idx == IDX_BODY_END) state_nx = ST_FCS;
      ST_FCS:  if (adv && idx == IDX_FCS_END) state_nx = ST_IFG;
      ST_IFG:  if (adv && ifg_cnt == IFG_LAST)
                 state_nx = (frame_cnt == count_q) ? ST_DONE : ST_PRE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Field latches, byte/nibble counters, running CRC and completed-frame count
  always_ff @(posedge sys_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      op_q      <= 1'b0;
      dst_mac_q <= '0;
      dst_ip_q  <= '0;
      count_q   <= '0;
      frame_cnt <= '0;
      idx       <= '0;
      ifg_cnt   <= '0;
      ph        <= 1'b0;
      crc       <= CRC32_INIT;
    end else begin
      if (state == ST_IDLE && start) begin
        op_q      <= op;
        dst_mac_q <= dst_mac;
        dst_ip_q  <= dst_ip;
        count_q   <= count;
        frame_cnt <= '0;
      end
      ph <= (tx_en || state == ST_IFG) ? ~ph : 1'b0;
      if (tx_en && adv) idx <= (idx == IDX_FCS_END) ? 7'd0 : idx + 7'd1;
      if (state == ST_IFG) begin
        if (adv) ifg_cnt <= ifg_cnt + 16'd1;
      end else begin
        ifg_cnt <= '0;
      end
      if (state == ST_PRE)              crc <= CRC32_INIT;
      else if (state == ST_BODY && adv) crc <= crc_next;
      if (state == ST_FCS && adv && idx == IDX_FCS_END && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Byte currently on the wire; zero outside the frame
  always_comb begin
    cur_byte = 8'h00;
    unique case (state)
      ST_PRE:  cur_byte = (idx == IDX_SFD) ? ETH_SFD : ETH_PREAMBLE;
      ST_BODY: cur_byte = body_byte(idx - 7'(ETH_PRE_BYTES), op_q, dst_mac_q, dst_ip_q);
      ST_FCS:  cur_byte = fcs[{idx[1:0], 3'b000} +: 8];
      default: cur_byte = 8'h00;
    endcase
  end

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (cur_byte),
    .crc_out (crc_next)
  );

  generate
    if (OUT_W == 8) begin : g_byte
      assign txd = cur_byte;
    end else begin : g_nibble
      assign txd = ph ? cur_byte[7:4] : cur_byte[3:0];
    end
  endgenerate

endmodule

// File: tb/tb_arp_frame_gen.sv
// tb/tb_arp_frame_gen.sv - self-checking bench for arp_frame_gen, byte and nibble variants
module tb_arp_frame_gen;

  logic        clk = 1'b0;
  logic        rst_n, start8, start4, op;
  logic [47:0] dst_mac;
  logic [31:0] dst_ip;
  logic [15:0] count;
  logic        busy8, done8, en8, busy4, done4, en4;
  logic [7:0]  txd8;
  logic [3:0]  txd4;
  logic [15:0] fc8, fc4;

  always #5 clk = ~clk;

  arp_frame_gen #(.OUT_W(8)) dut8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start8), .op(op), .dst_mac(dst_mac),
    .dst_ip(dst_ip), .count(count), .busy(busy8), .done(done8), .tx_en(en8),
    .txd(txd8), .frame_cnt(fc8));

  arp_frame_gen #(.OUT_W(4)) dut4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start4), .op(op), .dst_mac(dst_mac),
    .dst_ip(dst_ip), .count(count), .busy(busy4), .done(done4), .tx_en(en4),
    .txd(txd4), .frame_cnt(fc4));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] body_q[$];
  logic [7:0] frame_q[$];
  logic       e_en[$];
  logic [7:0] e_d[$];
  logic       t_en[$], t_busy[$], t_done[$];
  logic [7:0] t_d[$];
  logic [15:0] last_fc;

  task automatic put_field(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) body_q.push_back(v[i*8 +: 8]);
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Reference frame: fields laid out by the ARP/Ethernet rules, FCS by MSB-first polynomial division
  task automatic build_frame(input logic o, input logic [47:0] m, input logic [31:0] ip);
    logic [31:0] c;
    logic [31:0] f;
    logic        fb;
    body_q.delete();
    frame_q.delete();
    put_field(o ? {16'h0, m} : 64'hFFFF_FFFF_FFFF, 6);
    put_field(64'h0011_2233_4455, 6);
    put_field(64'h0806, 2);
    put_field(64'h0001, 2);
    put_field(64'h0800, 2);
    put_field(64'h06, 1);
    put_field(64'h04, 1);
    put_field(o ? 64'd2 : 64'd1, 2);
    put_field(64'h0011_2233_4455, 6);
    put_field(64'hC0A8_010A, 4);
    put_field(o ? {16'h0, m} : 64'h0, 6);
    put_field({32'h0, ip}, 4);
    while (body_q.size() < 60) body_q.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ body_q[k][b];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    f = ~rev32(c);
    for (int i = 0; i < 7; i++) frame_q.push_back(8'h55);
    frame_q.push_back(8'hD5);
    foreach (body_q[k]) frame_q.push_back(body_q[k]);
    for (int i = 0; i < 4; i++) frame_q.push_back(f[i*8 +: 8]);
  endtask

  task automatic build_expect(input bit w4, input int cnt);
    e_en.delete();
    e_d.delete();
    for (int f = 0; f < cnt; f++) begin
      foreach (frame_q[k]) begin
        if (w4) begin
          e_en.push_back(1'b1); e_d.push_back({4'h0, frame_q[k][3:0]});
          e_en.push_back(1'b1); e_d.push_back({4'h0, frame_q[k][7:4]});
        end else begin
          e_en.push_back(1'b1); e_d.push_back(frame_q[k]);
        end
      end
      for (int g = 0; g < (w4 ? 24 : 12); g++) begin
        e_en.push_back(1'b0); e_d.push_back(8'h00);
      end
    end
  endtask

  // One burst: record every cycle until done, optionally re-pulsing start mid-frame
  task automatic run_burst(input bit w4, input logic o, input logic [47:0] m,
                           input logic [31:0] ip, input logic [15:0] cnt, input int restart_at);
    bit          seen;
    int          budget;
    logic [63:0] r;
    string       tg;
    op = o; dst_mac = m; dst_ip = ip; count = cnt;
    t_en.delete(); t_d.delete(); t_busy.delete(); t_done.delete();
    budget = int'(cnt) * 200 + 20;
    if (w4) start4 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      t_en.push_back(w4 ? en4 : en8);
      t_d.push_back(w4 ? {4'h0, txd4} : txd8);
      t_busy.push_back(w4 ? busy4 : busy8);
      t_done.push_back(w4 ? done4 : done8);
      seen    = w4 ? done4 : done8;
      last_fc = w4 ? fc4 : fc8;
      r = {$urandom, $urandom};
      op = r[0]; dst_mac = r[47:0]; dst_ip = $urandom; count = r[63:48];
      if (n == restart_at) begin
        if (w4) start4 = 1'b1; else start8 = 1'b1;
      end else begin
        start4 = 1'b0; start8 = 1'b0;
      end
      if (!seen) @(negedge clk);
    end
    start4 = 1'b0; start8 = 1'b0;
    check("done_seen", 64'(seen), 64'd1);
    build_frame(o, m, ip);
    build_expect(w4, int'(cnt));
    check("burst_len", 64'(t_en.size()), 64'(e_en.size() + 1));
    for (int i = 0; i < e_en.size() && i < t_en.size(); i++) begin
      tg = $sformatf("w4=%0d cyc%0d", w4, i);
      check({tg, " tx_en"}, 64'(t_en[i]), 64'(e_en[i]));
      check({tg, " txd"}, 64'(t_d[i]), 64'(e_d[i]));
      check({tg, " busy"}, 64'(t_busy[i]), 64'(cnt != 16'd0));
      check({tg, " done"}, 64'(t_done[i]), 64'd0);
    end
    if (t_en.size() == e_en.size() + 1) begin
      check("end tx_en", 64'(t_en[e_en.size()]), 64'd0);
      check("end busy", 64'(t_busy[e_en.size()]), 64'(cnt != 16'd0));
    end
    check("frame_cnt", 64'(last_fc), 64'(cnt));
    @(negedge clk);
    check("idle busy", 64'(w4 ? busy4 : busy8), 64'd0);
    check("idle done", 64'(w4 ? done4 : done8), 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0; op = 1'b0;
    dst_mac = '0; dst_ip = '0; count = '0;
    repeat (3) @(negedge clk);
    check("rst tx_en8", 64'(en8), 64'd0);
    check("rst txd8", 64'(txd8), 64'd0);
    check("rst busy8", 64'(busy8), 64'd0);
    check("rst done8", 64'(done8), 64'd0);
    check("rst fc8", 64'(fc8), 64'd0);
    check("rst tx_en4", 64'(en4), 64'd0);
    check("rst txd4", 64'(txd4), 64'd0);
    check("rst fc4", 64'(fc4), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single request, byte bus
    run_burst(1'b0, 1'b0, 48'h1234_5678_9ABC, 32'hC0A8_0102, 16'd1, -1);
    // Three replies
    run_burst(1'b0, 1'b1, 48'h02AA_BBCC_DDEE, 32'hC0A8_0102, 16'd3, -1);
    // Single request, nibble bus
    run_burst(1'b1, 1'b0, 48'h1234_5678_9ABC, 32'hC0A8_0102, 16'd1, -1);
    // Empty burst
    run_burst(1'b0, 1'b0, 48'h0, 32'h0A00_0001, 16'd0, -1);
    // Start re-pulsed at byte 30 of frame 1
    run_burst(1'b0, 1'b1, 48'h02AA_BBCC_DDEE, 32'h0A01_0203, 16'd2, 30);

    // Reset at byte 40 of a frame
    op = 1'b0; dst_mac = '0; dst_ip = 32'hC0A8_0105; count = 16'd1;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (40) @(negedge clk);
    check("pre-rst tx_en", 64'(en8), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid-rst tx_en", 64'(en8), 64'd0);
    check("mid-rst txd", 64'(txd8), 64'd0);
    check("mid-rst busy", 64'(busy8), 64'd0);
    check("mid-rst frame_cnt", 64'(fc8), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post-rst tx_en", 64'(en8), 64'd0);
    check("post-rst busy", 64'(busy8), 64'd0);
    check("post-rst done", 64'(done8), 64'd0);
    r = {$urandom, $urandom};
    run_burst(1'b0, r[0], r[47:0], $urandom, 16'd1, -1);

    // Randomized bursts on both bus widths
    for (int k = 0; k < 4; k++) begin
      r = {$urandom, $urandom};
      run_burst(r[63], r[62], r[47:0], $urandom, 16'($urandom_range(1, 2)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
